cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the 4-lane common data bus (CDB) that writes results into the reorder buffer.
//  Up to NUM_REQ functional units offer {ROB tag, result} each cycle.
//  Grants up to NUM_LANES of them per cycle under round-robin priority.
//  Drives the ROB's cdb_valid_flat / indices_flat / new_values_flat from registers, one cycle after grant.
// PARAMETERS
//  NUM_REQ    6   functional-unit requesters (2..16)
//  NUM_LANES  4   CDB lanes per cycle; must equal ROB CDB width
//  TAG_W      4   ROB index width (16-entry ROB)
//  DATA_W     16  result width
// PORTS
//  clk              in   1                  clock, rising edge
//  rst_n            in   1                  asynchronous reset, active low
//  flush            in   1                  synchronous pipeline flush
//  req_valid        in   NUM_REQ            bit r: requester r offers a result
//  req_ready        out  NUM_REQ            bit r: requester r granted this cycle
//  req_tag          in   NUM_REQ*TAG_W      requester r tag at [r*TAG_W +: TAG_W]
//  req_data         in   NUM_REQ*DATA_W     requester r data at [r*DATA_W +: DATA_W]
//  cdb_valid_flat   out  NUM_LANES          lane k at bit NUM_LANES-1-k (lane 0 = MSB)
//  indices_flat     out  NUM_LANES*TAG_W    lane k at [TAG_W*(NUM_LANES-1-k) +: TAG_W]
//  new_values_flat  out  NUM_LANES*DATA_W   lane k at [DATA_W*(NUM_LANES-1-k) +: DATA_W]
// BEHAVIOUR
//  Reset (rst_n=0, async): cdb_valid/indices/values = 0; rr_ptr = 0; perf counters = 0.
//  req_ready is combinational and is 0 whenever rst_n=0.
//  Handshake:
//   - Transfer on req_valid[r] & req_ready[r].
//   - A requester holds valid, tag and data stable until the transfer.
//   - req_ready may depend on req_valid; req_valid must not depend on req_ready.
//  Grant:
//   - Scan r = rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//   - The first NUM_LANES requesters with req_valid=1 get req_ready=1.
//   - The j-th granted requester in scan order is packed into lane j; lanes are contiguous from lane 0.
//  Latency: granted tag/data appear on lane j at the next rising edge, valid exactly 1 cycle.
//   - Unused lanes: valid=0, tag=0, data=0.
//   - No back-pressure from the ROB; every registered lane is consumed.
//  rr_ptr update on a grant cycle: (index of last granted requester + 1) mod NUM_REQ.
//   - With no grant, rr_ptr holds.
//   - Effect: a requester left ungranted while others were served is scanned earlier next cycle.
//  Bound: <=NUM_LANES valid requesters -> all granted the same cycle; none waits.
//  Duplicate tags across requesters are not checked; they pass through (upstream guarantees uniqueness).
//  flush=1:
//   - req_ready = 0 for all requesters.
//   - Next edge: cdb_valid = 0 and rr_ptr = 0.
//   - Results held by requesters are not transferred; requesters drop them on flush.
//  Reset asserted mid-operation: registered lanes clear immediately (async); nothing in flight survives.
//  Width: rr_ptr is clog2(NUM_REQ) bits; modulo wrap is explicit since NUM_REQ need not be a power of 2.
// CONFIGURATION
//  CDB_ARB_PERF_EN defined: adds two outputs.
//   - perf_grants (out, 32): total transfers; adds popcount(req_valid & req_ready) per cycle.
//   - perf_conflicts (out, 32): cycles where popcount(req_valid) > NUM_LANES and flush=0.
//   - Both saturate at 32'hFFFF_FFFF; both clear on reset and on flush.
//  CDB_ARB_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
//  T1 reset: rst_n=0 with req_valid=all 1 -> req_ready=0, cdb_valid_flat=0000.
//     Release rst_n -> first grant is r0..r3.
//  T2 single: r2 valid, tag=5, data=16'hBEEF, cycle n -> req_ready=000100.
//     Cycle n+1: cdb_valid_flat=1000, lane0 tag=5, data=BEEF.
//     Cycle n+2: cdb_valid_flat=0000.
//  T3 oversubscribed: all 6 valid and held -> cycle 1 grants r0-r3 (lanes 0-3), rr_ptr=4.
//     Cycle 2 grants r4,r5 (lanes 0,1) if r0-r3 drop valid.
//     PERF build: perf_conflicts=1, perf_grants=6.
//  T4 wrap: rr_ptr=4, valid={r5,r0,r1,r2,r3} -> grants r5,r0,r1,r2 in lanes 0-3; r3 waits; rr_ptr=3.
//  T5 flush: flush=1 with r1 valid -> req_ready=0.
//     Next cycle: cdb_valid_flat=0000, rr_ptr=0, perf counters=0.
//  T6 async reset mid-burst: rst_n low between edges while cdb_valid_flat=1100.
//     Outputs go to 0 before the next edge.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter packing up to NUM_LANES functional-unit results per cycle onto the ROB's CDB.
// Optional performance counters are compiled in when CDB_ARB_PERF_EN is defined.
module cdb_arbiter #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_LANES = 4,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_LANES-1:0]          cdb_valid_flat,
  output logic [NUM_LANES*TAG_W-1:0]    indices_flat,
  output logic [NUM_LANES*DATA_W-1:0]   new_values_flat
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_grants,
  output logic [31:0]                   perf_conflicts
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [PTR_W-1:0]  rr_ptr_next;
  logic              grant_en;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_LANES-1:0] lane_valid_next;
  logic [NUM_LANES-1:0] lane_valid_reg;
  logic [TAG_W-1:0]  lane_tag_next  [NUM_LANES];
  logic [TAG_W-1:0]  lane_tag_reg   [NUM_LANES];
  logic [DATA_W-1:0] lane_data_next [NUM_LANES];
  logic [DATA_W-1:0] lane_data_reg  [NUM_LANES];
  int                grant_cnt;
  int                scan_idx;
  int                last_idx;

  // Ready is suppressed during reset and flush so nothing transfers in those cycles.
  assign grant_en  = rst_n & ~flush;
  assign req_ready = grant;

  always_comb begin
    grant     = '0;
    lane_valid_next = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_tag_next[k]  = '0;
      lane_data_next[k] = '0;
    end
    grant_cnt = 0;
    scan_idx  = 0;
    last_idx  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = int'(rr_ptr_reg) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (grant_en && req_valid[scan_idx] && grant_cnt < NUM_LANES) begin
        grant[scan_idx]            = 1'b1;
        lane_valid_next[grant_cnt] = 1'b1;
        lane_tag_next[grant_cnt]   = req_tag[scan_idx*TAG_W +: TAG_W];
        lane_data_next[grant_cnt]  = req_data[scan_idx*DATA_W +: DATA_W];
        last_idx  = scan_idx;
        grant_cnt = grant_cnt + 1;
      end
    end
  end

  // Pointer moves just past the last served requester so skipped ones lead next cycle.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (flush) begin
      rr_ptr_next = '0;
    end else if (grant_cnt > 0) begin
      if (last_idx + 1 >= NUM_REQ) rr_ptr_next = '0;
      else                         rr_ptr_next = PTR_W'(last_idx + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg     <= '0;
      lane_valid_reg <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        lane_tag_reg[k]  <= '0;
        lane_data_reg[k] <= '0;
      end
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      lane_valid_reg <= lane_valid_next;
      for (int k = 0; k < NUM_LANES; k++) begin
        lane_tag_reg[k]  <= lane_tag_next[k];
        lane_data_reg[k] <= lane_data_next[k];
      end
    end
  end

  // Lane 0 occupies the most significant slice of each flat bus.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign cdb_valid_flat[NUM_LANES-1-gi]                      = lane_valid_reg[gi];
      assign indices_flat[TAG_W*(NUM_LANES-1-gi) +: TAG_W]       = lane_tag_reg[gi];
      assign new_values_flat[DATA_W*(NUM_LANES-1-gi) +: DATA_W]  = lane_data_reg[gi];
    end
  endgenerate

`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_grants_reg;
  logic [31:0] perf_conflicts_reg;
  logic [32:0] grants_sum;
  int          valid_cnt;

  assign valid_cnt  = $countones(req_valid);
  assign grants_sum = {1'b0, perf_grants_reg} + 33'(grant_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants_reg    <= '0;
      perf_conflicts_reg <= '0;
    end else if (flush) begin
      perf_grants_reg    <= '0;
      perf_conflicts_reg <= '0;
    end else begin
      perf_grants_reg <= grants_sum[32] ? 32'hFFFF_FFFF : grants_sum[31:0];
      if (valid_cnt > NUM_LANES && perf_conflicts_reg != 32'hFFFF_FFFF)
        perf_conflicts_reg <= perf_conflicts_reg + 32'd1;
    end
  end

  assign perf_grants    = perf_grants_reg;
  assign perf_conflicts = perf_conflicts_reg;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a scan-list model.
module tb_cdb_arbiter;
  localparam int N  = 6;
  localparam int L  = 4;
  localparam int TW = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [L-1:0]    cdb_valid_flat;
  logic [L*TW-1:0] indices_flat;
  logic [L*DW-1:0] new_values_flat;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]     perf_grants;
  logic [31:0]     perf_conflicts;
`endif

  cdb_arbiter #(.NUM_REQ(N), .NUM_LANES(L), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data),
    .cdb_valid_flat(cdb_valid_flat), .indices_flat(indices_flat),
    .new_values_flat(new_values_flat)
`ifdef CDB_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // Model state: pending offers per requester, scan start, perf counts.
  bit            pv    [N];
  logic [TW-1:0] ptag  [N];
  logic [DW-1:0] pdata [N];
  int            m_ptr;
  longint        m_pg, m_pc;

  // Last observed DUT values, for literal pins.
  logic [N-1:0]    obs_rdy;
  logic [L-1:0]    obs_v;
  logic [L*TW-1:0] obs_idx;
  logic [L*DW-1:0] obs_val;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pg = 0; m_pc = 0;
    for (int r = 0; r < N; r++) pv[r] = 1'b0;
  endtask

  task automatic offer(input int r, input logic [TW-1:0] t, input logic [DW-1:0] d);
    pv[r] = 1'b1; ptag[r] = t; pdata[r] = d;
  endtask

  // One cycle: drive after negedge, check ready, then check registered lanes at next negedge.
  task automatic step(input bit fl, input bit verbose);
    logic [N-1:0]    e_rdy;
    logic [L-1:0]    e_v;
    logic [L*TW-1:0] e_idx;
    logic [L*DW-1:0] e_val;
    int q[$];
    int ng, nvalid;
    flush = fl;
    for (int r = 0; r < N; r++) begin
      req_valid[r]          = pv[r];
      req_tag[r*TW +: TW]   = ptag[r];
      req_data[r*DW +: DW]  = pdata[r];
    end
    #1;
    e_rdy = '0; e_v = '0; e_idx = '0; e_val = '0; ng = 0; nvalid = 0;
    for (int r = 0; r < N; r++) nvalid += int'(pv[r]);
    if (!fl) begin
      for (int i = 0; i < N; i++)
        if (pv[(m_ptr + i) % N]) q.push_back((m_ptr + i) % N);
      ng = (q.size() < L) ? q.size() : L;
      for (int j = 0; j < ng; j++) begin
        e_rdy[q[j]] = 1'b1;
        e_v[L-1-j]  = 1'b1;
        e_idx[TW*(L-1-j) +: TW] = ptag[q[j]];
        e_val[DW*(L-1-j) +: DW] = pdata[q[j]];
      end
      if (ng > 0) m_ptr = (q[ng-1] + 1) % N;
      m_pg += ng;
      if (nvalid > L) m_pc++;
      for (int j = 0; j < ng; j++) pv[q[j]] = 1'b0;
    end else begin
      m_ptr = 0; m_pg = 0; m_pc = 0;
      for (int r = 0; r < N; r++) pv[r] = 1'b0;
    end
    obs_rdy = req_ready;
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    @(negedge clk);
    obs_v = cdb_valid_flat; obs_idx = indices_flat; obs_val = new_values_flat;
    chk("cdb_valid", 64'(cdb_valid_flat), 64'(e_v));
    chk("indices", 64'(indices_flat), 64'(e_idx));
    chk("values", 64'(new_values_flat), 64'(e_val));
`ifdef CDB_ARB_PERF_EN
    chk("perf_grants", 64'(perf_grants), 64'(m_pg));
    chk("perf_conflicts", 64'(perf_conflicts), 64'(m_pc));
`endif
    if (verbose)
      $display("xfer flush=%0b ready=%b lanes=%b idx=%h val=%h", fl, obs_rdy, obs_v, obs_idx, obs_val);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    model_reset();
    for (int r = 0; r < N; r++) offer(r, TW'(r + 8), DW'(16'h1000 + r));
    req_valid = '1; req_tag = '0; req_data = '0;
    for (int r = 0; r < N; r++) begin
      req_tag[r*TW +: TW]  = ptag[r];
      req_data[r*DW +: DW] = pdata[r];
    end
    // T1: reset holds ready low and lanes clear.
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(cdb_valid_flat), 64'h0);
    repeat (2) @(negedge clk);
    chk("rst_valid_held", 64'(cdb_valid_flat), 64'h0);
    rst_n = 1'b1;

    // T1/T3: first grant r0..r3, then r4,r5.
    step(1'b0, 1'b1);
    chk("t1_ready", 64'(obs_rdy), 64'b001111);
    chk("t1_valid", 64'(obs_v), 64'b1111);
    chk("t1_idx", 64'(obs_idx), 64'h89AB);
    step(1'b0, 1'b1);
    chk("t3_ready", 64'(obs_rdy), 64'b110000);
    chk("t3_valid", 64'(obs_v), 64'b1100);
    chk("t3_val", 64'(obs_val), 64'h1004_1005_0000_0000);
`ifdef CDB_ARB_PERF_EN
    chk("t3_pgrants", 64'(perf_grants), 64'd6);
    chk("t3_pconf", 64'(perf_conflicts), 64'd1);
`endif

    // T4: move pointer to 4, then wrap r5,r0,r1,r2; r3 waits.
    for (int r = 0; r < 4; r++) offer(r, TW'(r), DW'(r));
    step(1'b0, 1'b1);
    offer(5, 4'd5, 16'h0555); offer(0, 4'd0, 16'h0000); offer(1, 4'd1, 16'h0111);
    offer(2, 4'd2, 16'h0222); offer(3, 4'd3, 16'h0333);
    step(1'b0, 1'b1);
    chk("t4_ready", 64'(obs_rdy), 64'b100111);
    chk("t4_idx", 64'(obs_idx), 64'h5012);
    step(1'b0, 1'b1);
    chk("t4_r3_ready", 64'(obs_rdy), 64'b001000);

    // T2: single requester lands in lane 0, valid one cycle.
    offer(2, 4'd5, 16'hBEEF);
    step(1'b0, 1'b1);
    chk("t2_ready", 64'(obs_rdy), 64'b000100);
    chk("t2_valid", 64'(obs_v), 64'b1000);
    chk("t2_idx", 64'(obs_idx), 64'h5000);
    chk("t2_val", 64'(obs_val), 64'hBEEF_0000_0000_0000);
    step(1'b0, 1'b1);
    chk("t2_idle", 64'(obs_v), 64'b0000);

    // T5: flush blocks ready, clears lanes and pointer.
    offer(1, 4'd7, 16'h7777);
    step(1'b1, 1'b1);
    chk("t5_ready", 64'(obs_rdy), 64'b000000);
    chk("t5_valid", 64'(obs_v), 64'b0000);
    for (int r = 0; r < N; r++) offer(r, TW'(r), DW'(16'hA0 + r));
    step(1'b0, 1'b1);
    chk("t5_ptr0", 64'(obs_rdy), 64'b001111);
    step(1'b0, 1'b0);

    // T6: asynchronous reset between edges clears live lanes.
    offer(0, 4'd3, 16'h3333); offer(1, 4'd4, 16'h4444);
    step(1'b0, 1'b1);
    chk("t6_pre", 64'(obs_v), 64'b1100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(cdb_valid_flat), 64'h0);
    chk("t6_idx", 64'(indices_flat), 64'h0);
    chk("t6_val", 64'(new_values_flat), 64'h0);
    chk("t6_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int r = 0; r < N; r++) offer(r, TW'(r + 1), DW'(r));
    step(1'b0, 1'b1);
    chk("t6_after", 64'(obs_rdy), 64'b001111);

    // Randomized traffic; requesters hold offers until granted.
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++)
        if (!pv[r] && $urandom_range(0, 9) < 5)
          offer(r, TW'($urandom), DW'($urandom));
      step($urandom_range(0, 19) == 0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
